// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile
// I2C target with a local byte-addressed register file. Frame: START,
// 8-bit device address (MSB first), R/W bit, ACK, 8-bit memory address,
// ACK, data byte, ACK/NACK, STOP. SCL/SDA are oversampled on clk; SDA is
// driven open-drain through sda_oe.
//
// Optional build macro: I2C_SLAVE_AUTOINC_EN
//   defined   - memory address auto-increments for multi-byte transfers
//   undefined - one data byte per transfer
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   scl_in     bus SCL level
//   sda_in     bus SDA level
//   sda_oe     1 = pull SDA low, 0 = release
//   wr_valid   one-cycle pulse when a bus write commits
//   wr_addr    register address of the committed write
//   wr_data    data of the committed write
//   loc_addr   local read address
//   loc_rdata  registered local read data (1-cycle latency)
//   busy       high from START to STOP while addressed
//
// state        | meaning
// S_IDLE       | waiting for START
// S_DEV_ADDR   | shifting in the 8-bit device address
// S_RW         | sampling the R/W bit, address compare
// S_ACK_DEV    | driving ACK for the device address
// S_MEM_ADDR   | shifting in the memory address
// S_ACK_MEM    | ACK if address in range, NACK otherwise
// S_WRITE_DATA | shifting in a write data byte
// S_ACK_WRITE  | driving ACK for the committed write byte
// S_READ_DATA  | driving a read byte, MSB first
// S_ACK_READ   | released, sampling master ACK/NACK
// S_WAIT_STOP  | released, ignoring SCL until START/STOP

module i2c_slave_regfile #(
    parameter logic [7:0] DEV_ADDR    = 8'h01,
    parameter int         DEPTH       = 64,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     scl_in,
    input  logic                     sda_in,
    output logic                     sda_oe,
    output logic                     wr_valid,
    output logic [7:0]               wr_addr,
    output logic [7:0]               wr_data,
    input  logic [$clog2(DEPTH)-1:0] loc_addr,
    output logic [7:0]               loc_rdata,
    output logic                     busy
);

    localparam int         AW     = $clog2(DEPTH);
    localparam logic [8:0] DEPTH9 = 9'(DEPTH);

    typedef enum logic [3:0] {
        S_IDLE, S_DEV_ADDR, S_RW, S_ACK_DEV, S_MEM_ADDR, S_ACK_MEM,
        S_WRITE_DATA, S_ACK_WRITE, S_READ_DATA, S_ACK_READ, S_WAIT_STOP
    } state_t;

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n;
    logic [7:0] mem_addr, mem_addr_n;
    logic       rw, rw_n;
    logic       sda_oe_n, busy_n, wr_en;
    logic [7:0] mem [DEPTH];

    // Synchronizers reset to 1 (idle bus) so no false edge follows reset.
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_d, sda_d, scl_s, sda_s;
    logic scl_rise, scl_fall, start_det, stop_det;
    logic mem_ok;
    logic [7:0] wr_byte;

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign mem_ok    = {1'b0, mem_addr} < DEPTH9;
    assign wr_byte   = {shift[6:0], sda_s};

`ifdef I2C_SLAVE_AUTOINC_EN
    logic [8:0] inc_addr9;
    logic       inc_ok;
    assign inc_addr9 = {1'b0, mem_addr} + 9'd1;
    assign inc_ok    = inc_addr9 < DEPTH9;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            mem_addr  <= '0;
            rw        <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            loc_rdata <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift     <= shift_n;
            mem_addr  <= mem_addr_n;
            rw        <= rw_n;
            sda_oe    <= sda_oe_n;
            busy      <= busy_n;
            wr_valid  <= wr_en;
            // Read before write in the same cycle: old value returned.
            loc_rdata <= mem[loc_addr];
            if (wr_en) begin
                mem[mem_addr[AW-1:0]] <= wr_byte;
                wr_addr               <= mem_addr;
                wr_data               <= wr_byte;
            end
        end
    end

    // SDA output only moves on SCL fall; decisions are taken on SCL rise.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        mem_addr_n = mem_addr;
        rw_n       = rw;
        sda_oe_n   = sda_oe;
        busy_n     = busy;
        wr_en      = 1'b0;
        if (stop_det) begin
            state_n  = S_IDLE;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
        end else if (start_det) begin
            state_n   = S_DEV_ADDR;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
        end else if (scl_fall) begin
            case (state)
                S_ACK_DEV, S_ACK_WRITE: sda_oe_n = 1'b1;
                S_ACK_MEM:              sda_oe_n = mem_ok;
                S_READ_DATA: begin
                    sda_oe_n = ~shift[7];
                    shift_n  = {shift[6:0], 1'b0};
                end
                default:                sda_oe_n = 1'b0;
            endcase
        end else if (scl_rise) begin
            case (state)
                S_DEV_ADDR, S_MEM_ADDR, S_WRITE_DATA: begin
                    shift_n   = wr_byte;
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        case (state)
                            S_DEV_ADDR: state_n = S_RW;
                            S_MEM_ADDR: begin
                                state_n    = S_ACK_MEM;
                                mem_addr_n = wr_byte;
                            end
                            default: begin
                                state_n = S_ACK_WRITE;
                                wr_en   = 1'b1;
                            end
                        endcase
                    end
                end
                S_RW: begin
                    rw_n = sda_s;
                    if (shift == DEV_ADDR) begin
                        state_n = S_ACK_DEV;
                        busy_n  = 1'b1;
                    end else begin
                        state_n = S_WAIT_STOP;
                    end
                end
                S_ACK_DEV: begin
                    state_n   = S_MEM_ADDR;
                    bit_cnt_n = '0;
                end
                S_ACK_MEM: begin
                    bit_cnt_n = '0;
                    if (!mem_ok) begin
                        state_n = S_WAIT_STOP;
                    end else if (rw) begin
                        state_n = S_READ_DATA;
                        shift_n = mem[mem_addr[AW-1:0]];
                    end else begin
                        state_n = S_WRITE_DATA;
                    end
                end
                S_READ_DATA: begin
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = S_ACK_READ;
                end
`ifdef I2C_SLAVE_AUTOINC_EN
                S_ACK_WRITE: begin
                    bit_cnt_n = '0;
                    if (inc_ok) begin
                        mem_addr_n = inc_addr9[7:0];
                        state_n    = S_WRITE_DATA;
                    end else begin
                        state_n = S_WAIT_STOP;
                    end
                end
                S_ACK_READ: begin
                    bit_cnt_n = '0;
                    if (!sda_s && inc_ok) begin
                        mem_addr_n = inc_addr9[7:0];
                        shift_n    = mem[inc_addr9[AW-1:0]];
                        state_n    = S_READ_DATA;
                    end else begin
                        state_n = S_WAIT_STOP;
                    end
                end
`else
                S_ACK_WRITE, S_ACK_READ: state_n = S_WAIT_STOP;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Testbench for i2c_slave_regfile: a bus master model drives directed
// transactions; expected responses go into queues and monitor processes
// compare them when the DUT presents them.
module tb_i2c_slave_regfile;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_oe, wr_valid, busy;
    logic [7:0] wr_addr, wr_data, loc_rdata;
    logic [5:0] loc_addr = '0;
    logic       sda_bus;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave_regfile #(.DEV_ADDR(8'h01), .DEPTH(64), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .scl_in(scl), .sda_in(sda_bus),
        .sda_oe(sda_oe), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_data(wr_data), .loc_addr(loc_addr), .loc_rdata(loc_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    logic        sda_q[$];
    string       sda_name_q[$];
    logic [15:0] wr_q[$];
    logic [7:0]  rd_q[$];
    logic        busy_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // ---------------- monitors ----------------
    always @(posedge scl) begin
        if (sda_q.size() > 0) begin
            string nm;
            logic  e;
            nm = sda_name_q.pop_front();
            e  = sda_q.pop_front();
            #40;
            check(nm, {31'b0, sda_oe}, {31'b0, e});
        end
    end

    always @(negedge clk) begin
        if (wr_valid === 1'b1) begin
            if (wr_q.size() == 0) begin
                fail_now("wr_valid_unexpected");
            end else begin
                logic [15:0] e;
                e = wr_q.pop_front();
                check("wr_addr", {24'b0, wr_addr}, {24'b0, e[15:8]});
                check("wr_data", {24'b0, wr_data}, {24'b0, e[7:0]});
            end
        end
        if (rd_q.size() > 0) check("loc_rdata", {24'b0, loc_rdata}, {24'b0, rd_q.pop_front()});
        if (busy_q.size() > 0) check("busy", {31'b0, busy}, {31'b0, busy_q.pop_front()});
    end

    // ---------------- bus master ----------------
    task automatic bit_slot(input logic b, input bit chk, input logic exp, input string name);
        sda_m = b;
        #40;
        if (chk) begin
            sda_q.push_back(exp);
            sda_name_q.push_back(name);
        end
        scl = 1'b1;
        #80;
        scl = 1'b0;
        #40;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) bit_slot(v[i], 1'b0, 1'b0, "");
    endtask

    task automatic ack_slot(input logic exp, input string name);
        bit_slot(1'b1, 1'b1, exp, name);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #40;
        scl = 1'b1;   #40;
        sda_m = 1'b0; #40;
        scl = 1'b0;   #40;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #40;
        scl = 1'b1;   #40;
        sda_m = 1'b1; #40;
    endtask

    task automatic loc_read(input logic [5:0] a, input logic [7:0] exp);
        @(negedge clk); #1;
        loc_addr = a;
        rd_q.push_back(exp);
        @(negedge clk); #1;
    endtask

    task automatic busy_probe(input logic exp);
        @(negedge clk); #1;
        busy_q.push_back(exp);
        @(negedge clk); #1;
    endtask

    task automatic addr_phase(input logic [7:0] dev, input logic rw, input logic e_dev,
                              input logic [7:0] madr, input logic e_mem, input string tag);
        i2c_start();
        send_byte(dev);
        bit_slot(rw, 1'b0, 1'b0, "");
        ack_slot(e_dev, {tag, "_ack_dev"});
        send_byte(madr);
        ack_slot(e_mem, {tag, "_ack_mem"});
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rbyte;

        // reset state
        repeat (4) @(posedge clk);
        #1;
        check("rst_sda_oe",    {31'b0, sda_oe},   0);
        check("rst_wr_valid",  {31'b0, wr_valid}, 0);
        check("rst_wr_addr",   {24'b0, wr_addr},  0);
        check("rst_wr_data",   {24'b0, wr_data},  0);
        check("rst_loc_rdata", {24'b0, loc_rdata}, 0);
        check("rst_busy",      {31'b0, busy},     0);
        @(negedge clk); reset = 1'b0;
        repeat (5) @(posedge clk);

        // T1: single write mem[5] = A5
        addr_phase(8'h01, 1'b0, 1'b1, 8'h05, 1'b1, "t1");
        wr_q.push_back({8'h05, 8'hA5});
        send_byte(8'hA5);
        ack_slot(1'b1, "t1_ack_wr");
        busy_probe(1'b1);
        i2c_stop();
        busy_probe(1'b0);
        loc_read(6'd5, 8'hA5);

        // T2: read mem[5], master NACK
        addr_phase(8'h01, 1'b1, 1'b1, 8'h05, 1'b1, "t2");
        rbyte = 8'hA5;
        for (int i = 7; i >= 0; i--) bit_slot(1'b1, 1'b1, ~rbyte[i], "t2_rd_bit");
        ack_slot(1'b0, "t2_nack_slot");
        busy_probe(1'b1);
        i2c_stop();
        busy_probe(1'b0);

        // T3: device address mismatch
        addr_phase(8'h03, 1'b0, 1'b0, 8'h05, 1'b0, "t3");
        send_byte(8'h5A);
        ack_slot(1'b0, "t3_ack_wr");
        busy_probe(1'b0);
        i2c_stop();
        busy_probe(1'b0);

        // T4: memory address out of range
        addr_phase(8'h01, 1'b0, 1'b1, 8'h40, 1'b0, "t4");
        send_byte(8'h77);
        ack_slot(1'b0, "t4_ack_wr");
        i2c_stop();
        loc_read(6'd0, 8'h00);

        // T5: repeated START mid data byte, then a full write
        addr_phase(8'h01, 1'b0, 1'b1, 8'h02, 1'b1, "t5a");
        for (int i = 0; i < 4; i++) bit_slot(1'b1, 1'b0, 1'b0, "");
        addr_phase(8'h01, 1'b0, 1'b1, 8'h02, 1'b1, "t5b");
        wr_q.push_back({8'h02, 8'h3C});
        send_byte(8'h3C);
        ack_slot(1'b1, "t5_ack_wr");
        i2c_stop();
        loc_read(6'd2, 8'h3C);
        loc_read(6'd5, 8'hA5);

        // T6: reset while target drives the device ACK
        i2c_start();
        send_byte(8'h01);
        bit_slot(1'b0, 1'b0, 1'b0, "");
        #20;
        check("t6_oe_driving", {31'b0, sda_oe}, 1);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("t6_oe_async_rst", {31'b0, sda_oe}, 0);
        scl = 1'b1;
        sda_m = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        repeat (5) @(posedge clk);
        i2c_start();
        send_byte(8'h01);
        bit_slot(1'b0, 1'b0, 1'b0, "");
        ack_slot(1'b1, "t6_ack_after_rst");
        i2c_stop();
        loc_read(6'd5, 8'h00);

        // T7: three data bytes starting at 3E
        addr_phase(8'h01, 1'b0, 1'b1, 8'h3E, 1'b1, "t7");
        wr_q.push_back({8'h3E, 8'h11});
        send_byte(8'h11);
        ack_slot(1'b1, "t7_ack_b1");
`ifdef I2C_SLAVE_AUTOINC_EN
        wr_q.push_back({8'h3F, 8'h22});
        send_byte(8'h22);
        ack_slot(1'b1, "t7_ack_b2");
        send_byte(8'h33);
        ack_slot(1'b0, "t7_nack_b3");
        i2c_stop();
        loc_read(6'h3E, 8'h11);
        loc_read(6'h3F, 8'h22);
`else
        send_byte(8'h22);
        ack_slot(1'b0, "t7_nack_b2");
        send_byte(8'h33);
        ack_slot(1'b0, "t7_nack_b3");
        i2c_stop();
        loc_read(6'h3E, 8'h11);
        loc_read(6'h3F, 8'h00);
`endif

        #400;
        while (wr_q.size() > 0) begin
            void'(wr_q.pop_front());
            fail_now("wr_valid_missing");
        end
        while (sda_q.size() > 0) begin
            void'(sda_q.pop_front());
            fail_now("sda_slot_unchecked");
        end
        while (rd_q.size() > 0) begin
            void'(rd_q.pop_front());
            fail_now("loc_read_unchecked");
        end
        while (busy_q.size() > 0) begin
            void'(busy_q.pop_front());
            fail_now("busy_unchecked");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
